// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment code table and scan-decoder FSM states
package seg7_pkg;

    // Segment patterns in {a,b,c,d,e,f,g} order, active-high, a = bit 6
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - segment pattern to BCD / blank / invalid classifier
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] leds,
    output logic [3:0] bcd,
    output logic       is_blank,
    output logic       invalid
);

    always_comb begin
        bcd      = 4'd0;
        is_blank = 1'b0;
        invalid  = 1'b0;
        case (leds)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - reconstructs per-digit BCD from a scanned 7-segment bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    localparam int IDX_W     = $clog2(NDIG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          leds,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     blank,
    output logic                upd,
    output logic [IDX_W-1:0]    upd_idx,
    output logic                err,
    output logic                frame_done
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    logic [NDIG-1:0]       sel_q, sel_p;
    logic [6:0]            leds_q, leds_p;
    fsm_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [NDIG-1:0]       seen;
    logic [NDIG-1:0][3:0]  dig_q;

    logic                  onehot, same;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            bcd;
    logic                  is_blank, invalid;
    logic [NDIG-1:0]       seen_set;

    seg7_pattern_decode u_decode (
        .leds     (leds_q),
        .bcd      (bcd),
        .is_blank (is_blank),
        .invalid  (invalid)
    );

    always_comb begin
        onehot = (sel_q != '0) && ((sel_q & (sel_q - NDIG'(1))) == '0);
        same   = (sel_q == sel_p) && (leds_q == leds_p);
        idx    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_q[i]) idx = IDX_W'(i);
        end
        seen_set = seen | (NDIG'(1) << idx);
    end

    assign digits = dig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            sel_p      <= '0;
            leds_q     <= '0;
            leds_p     <= '0;
            state      <= IDLE;
            cnt        <= '0;
            seen       <= '0;
            dig_q      <= '0;
            blank      <= '1;
            upd        <= 1'b0;
            upd_idx    <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sel_q      <= dig_sel;
            leds_q     <= leds;
            sel_p      <= sel_q;
            leds_p     <= leds_q;
            upd        <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (onehot) begin
                        state <= TRACK;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (!same) begin
                        state <= onehot ? TRACK : IDLE;
                        cnt   <= onehot ? CNT_W'(1) : '0;
                    end else if (state == TRACK) begin
                        if (cnt >= CNT_W'(STABLE_CYC - 1)) begin
                            // Stable long enough: capture once, then hold until the pair changes
                            state <= HOLD;
                            cnt   <= CNT_W'(STABLE_CYC);
                            if (invalid) begin
                                err <= 1'b1;
                            end else begin
                                upd     <= 1'b1;
                                upd_idx <= idx;
                                if (is_blank) begin
                                    blank[idx] <= 1'b1;
                                end else begin
                                    blank[idx] <= 1'b0;
                                    dig_q[idx] <= bcd;
                                end
                                if (&seen_set) begin
                                    frame_done <= 1'b1;
                                    seen       <= '0;
                                end else begin
                                    seen       <= seen_set;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  leds;
    logic [3:0]  dig_sel;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_upd   = 0;
    int n_err   = 0;
    int n_fd    = 0;
    int fd_idx  = -1;
    int base_upd, base_err, base_fd;

    seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .leds       (leds),
        .dig_sel    (dig_sel),
        .digits     (digits),
        .blank      (blank),
        .upd        (upd),
        .upd_idx    (upd_idx),
        .err        (err),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (upd) n_upd++;
        if (err) n_err++;
        if (frame_done) begin
            n_fd++;
            fd_idx = upd ? int'(upd_idx) : -2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; leds = 7'b0; dig_sel = 4'b0;
        tick(2);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_blank", 32'(blank), 32'hF);
        chk("reset_upd", 32'(upd), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_fd", 32'(frame_done), 32'h0);
        chk("reset_idx", 32'(upd_idx), 32'h0);

        // Basic capture: digit 1 shows 5
        rst = 1'b0;
        dig_sel = 4'b0010; leds = 7'b1011011;
        base_upd = n_upd; base_err = n_err;
        tick(4);
        chk("basic_early", 32'(upd), 32'h0);
        tick(1);
        chk("basic_upd", 32'(upd), 32'h1);
        chk("basic_idx", 32'(upd_idx), 32'h1);
        chk("basic_digits", 32'(digits), 32'h0050);
        chk("basic_blank", 32'(blank), 32'hD);
        tick(20);
        chk("basic_single_upd", 32'(n_upd - base_upd), 32'h1);
        chk("basic_no_err", 32'(n_err - base_err), 32'h0);

        // Glitch: 0 for 3 cycles then 3 for 4 cycles
        base_upd = n_upd;
        leds = 7'b1111110;
        tick(3);
        leds = 7'b1111001;
        tick(4);
        chk("glitch_early", 32'(upd), 32'h0);
        tick(1);
        chk("glitch_upd", 32'(upd), 32'h1);
        chk("glitch_digits", 32'(digits), 32'h0030);
        tick(5);
        chk("glitch_count", 32'(n_upd - base_upd), 32'h1);

        // Invalid pattern, then blank
        leds = 7'b1000001;
        tick(5);
        chk("inv_err", 32'(err), 32'h1);
        chk("inv_upd", 32'(upd), 32'h0);
        chk("inv_digits", 32'(digits), 32'h0030);
        tick(1);
        chk("inv_err_pulse", 32'(err), 32'h0);
        leds = 7'b0000000;
        tick(5);
        chk("blank_upd", 32'(upd), 32'h1);
        chk("blank_idx", 32'(upd_idx), 32'h1);
        chk("blank_mask", 32'(blank), 32'hF);
        chk("blank_digits", 32'(digits), 32'h0030);

        // Non-one-hot strobes
        dig_sel = 4'b0000; leds = 7'b1111111;
        tick(1);
        base_upd = n_upd; base_err = n_err;
        tick(10);
        dig_sel = 4'b0110;
        tick(10);
        chk("strobe_no_upd", 32'(n_upd - base_upd), 32'h0);
        chk("strobe_no_err", 32'(n_err - base_err), 32'h0);

        // Reset mid-TRACK, then a full-latency capture
        dig_sel = 4'b0001; leds = 7'b1110010;
        tick(3);
        rst = 1'b1;
        #2;
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_blank", 32'(blank), 32'hF);
        chk("midrst_upd", 32'(upd), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("midrst_early", 32'(upd), 32'h0);
        tick(1);
        chk("midrst_upd_after", 32'(upd), 32'h1);
        chk("midrst_digits_after", 32'(digits), 32'h0007);

        // Frame: digits 0..3 show 1,2,3,4
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        base_upd = n_upd; base_fd = n_fd;
        for (int i = 0; i < 4; i++) begin
            dig_sel = 4'(1 << i);
            case (i)
                0: leds = 7'b0110000;
                1: leds = 7'b1101101;
                2: leds = 7'b1111001;
                default: leds = 7'b0110011;
            endcase
            tick(6);
        end
        chk("frame_upds", 32'(n_upd - base_upd), 32'h4);
        chk("frame_done_cnt", 32'(n_fd - base_fd), 32'h1);
        chk("frame_done_idx", 32'(fd_idx), 32'h3);
        chk("frame_digits", 32'(digits), 32'h4321);
        chk("frame_blank", 32'(blank), 32'h0);
        base_upd = n_upd; base_fd = n_fd;
        dig_sel = 4'b0001; leds = 7'b0110000;
        tick(8);
        chk("rescan_upd", 32'(n_upd - base_upd), 32'h1);
        chk("rescan_no_fd", 32'(n_fd - base_fd), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
